avalon_interval_timer: RTL
==========================

# avalon_interval_timer

Parametrised successor to the fixed-period processor-node interval timer. It is a down-counter of configurable width behind a 16-bit Avalon-MM slave, with these additions:
- writable period
- start/stop and one-shot/continuous control
- counter snapshot
- single-cycle timeout strobe output

Each NIOS node instantiates one as its system tick or benchmark timer. The IRQ goes to the node's interrupt controller.

## Interface
- COUNTER_W, 32, counter/period width; legal range 17..32
- RESET_PERIOD, 32'h0002_2E97, period and counter value after reset; bits above COUNTER_W ignored
- ALWAYS_RUN, 0, 1 = counter runs from reset in continuous mode; STOP, CONT and period-write stop are ignored

- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write
- writedata  in  16  write data
- readdata  out  16  registered read data
- irq  out  1  TO & ITO, level
- timeout_pulse  out  1  high for exactly the cycle after each timeout event

## Operation
- Write strobe: wr = chipselect & ~write_n. Writes take effect at the next edge.
- Register map:
  - 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
    - START and STOP are write-1 strobes and read as 0.
    - Stored bits [1:0] read back.
  - 2 PERIOD_L: period[15:0].
  - 3 PERIOD_H: period[COUNTER_W-1:16]. Unused bits write-ignored and read 0.
  - 4 SNAP_L / 5 SNAP_H: read the snapshot register. A write of any data to either one copies the live counter into the snapshot.
  - Addresses 6 and 7 read 0; writes to them are ignored.
- Counter behaviour:
  - While RUN=1 and counter≠0, the counter decrements by 1.
  - While RUN=1 and counter=0 (timeout event):
    - counter ← period
    - TO ← 1
    - timeout_pulse ← 1
    - if CONT=0, RUN ← 0
  - While RUN=0, the counter holds.
- START sets RUN. The counter continues from its current value and is not reloaded.
- STOP clears RUN. If START and STOP are written together, STOP wins.
- A write to PERIOD_L or PERIOD_H:
  - updates that half of the period
  - reloads the counter with the new period at the following edge
  - clears RUN, unless ALWAYS_RUN=1
- Period 0 with CONT=1 gives a timeout every cycle. timeout_pulse then stays high continuously.
- Collision rules:
  - STATUS write and timeout event in the same cycle: TO ends at 1 (set wins).
  - Period write and timeout event in the same cycle: the counter loads the new period, and the timeout is still flagged.
- Reset values:
  - counter = period = RESET_PERIOD
  - CONTROL = {CONT=ALWAYS_RUN, ITO=0}
  - RUN = ALWAYS_RUN
  - TO = 0, snapshot = 0, readdata = 0, irq = 0, timeout_pulse = 0
- Reset asserted mid-count overrides every concurrent write and event.

## Timing
- readdata is re-registered every cycle from the address mux, regardless of chipselect. Data for the address presented at cycle t is valid at t+1. Zero wait states.
- START written at edge t:
  - RUN=1 after t.
  - The first decrement occurs at edge t+1.
  - Starting from a freshly loaded period P, the timeout event occurs P+1 cycles after RUN rises.
- Continuous mode: timeout events are spaced exactly P+1 cycles apart.
- irq rises in the same cycle TO becomes 1, and falls the cycle after a STATUS write or after ITO is cleared.
- A snapshot captures the counter value present at the write edge. It is readable from the next cycle.

## Structure
- Shared package timer_pkg holds:
  - address constants: ADDR_STATUS..ADDR_SNAP_H
  - CONTROL bit indices: CTRL_ITO, CTRL_CONT, CTRL_START, CTRL_STOP
  - STATUS bit indices
- One sub-module, interval_timer_core, contains the counter, RUN and reload logic. Its inputs are load, load_value, start, stop, cont and always_run; its outputs are count, run and timeout.
- The top level holds the register file, TO/irq, snapshot and the read mux.

## Test plan
- Reset with defaults → RUN=0, counter=0x22E97, readdata=0, irq=0; STATUS reads 0x0000.
- Period 9, CONT=1, ITO=1, START → timeout_pulse every 10 cycles; irq stays high until a STATUS write, then drops next cycle and re-rises on the next timeout.
- Period 4, CONT=0, START → one timeout 5 cycles after RUN rises, then RUN=0 and the counter holds at 4.
- Period 0x12345, running, write SNAP_L mid-count → SNAP_L/SNAP_H read back the counter value at the write edge; the counter keeps decrementing.
- Collisions:
  - START and STOP in one write → RUN stays 0.
  - STATUS write coincident with a timeout → TO remains 1.
  - Period write coincident with a timeout → counter = new period, RUN=0.
- ALWAYS_RUN=1 → RUN=1 from reset; STOP and period writes do not stop the counter; events every 0x22E98 cycles after reset.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the Avalon-MM interval timer: register map and bit positions.
package timer_pkg;

    // Register addresses (word offsets on the 3-bit address bus)
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    // CONTROL bit positions; START and STOP are write-only strobes
    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    // STATUS bit positions
    localparam int unsigned STAT_TO  = 0;
    localparam int unsigned STAT_RUN = 1;

endpackage

// File: rtl/interval_timer_core.sv
// Down-counter with run control and reload; flags a timeout while running at zero.
module interval_timer_core #(
    parameter int unsigned          COUNTER_W   = 32,
    parameter logic [COUNTER_W-1:0] RESET_COUNT = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [COUNTER_W-1:0] load_value,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 cont,
    input  logic                 always_run,
    output logic [COUNTER_W-1:0] count,
    output logic                 run,
    output logic                 timeout
);

    localparam logic [COUNTER_W-1:0] ONE = {{(COUNTER_W-1){1'b0}}, 1'b1};

    logic [COUNTER_W-1:0] count_q, count_d;
    logic                 run_q, run_d;

    assign timeout = run_q && (count_q == '0);
    assign count   = count_q;
    assign run     = run_q;

    // Next count and run state; load_value already carries any same-cycle period write
    always_comb begin
        count_d = count_q;
        run_d   = run_q;

        if (load || timeout) begin
            count_d = load_value;
        end else if (run_q) begin
            count_d = count_q - ONE;
        end

        if (always_run) begin
            run_d = 1'b1;
        end else if (stop) begin
            run_d = 1'b0;
        end else if (load) begin
            run_d = 1'b0;
        end else if (start) begin
            run_d = 1'b1;
        end else if (timeout && !cont) begin
            run_d = 1'b0;
        end
    end

    // Counter and run flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_COUNT;
            run_q   <= always_run;
        end else begin
            count_q <= count_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/avalon_interval_timer.sv
// Interval timer behind a 16-bit Avalon-MM slave: registers, TO/irq, snapshot, read mux.
module avalon_interval_timer
    import timer_pkg::*;
#(
    parameter int unsigned COUNTER_W    = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h0002_2E97,
    parameter bit          ALWAYS_RUN   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        timeout_pulse
);

    localparam int unsigned          HI_W       = COUNTER_W - 16;
    localparam logic [COUNTER_W-1:0] RESET_VAL  = RESET_PERIOD[COUNTER_W-1:0];
    localparam logic [1:0]           CTRL_RESET = {ALWAYS_RUN, 1'b0};

    logic                 wr;
    logic                 wr_status, wr_ctrl, wr_per_l, wr_per_h, wr_snap;
    logic [COUNTER_W-1:0] period_q, period_d;
    logic [COUNTER_W-1:0] snap_q, snap_d;
    logic [1:0]           ctrl_q, ctrl_d;
    logic                 to_q, to_d;
    logic                 pulse_q, pulse_d;
    logic [15:0]          readdata_q, readdata_d;
    logic [COUNTER_W-1:0] count;
    logic                 run;
    logic                 timeout;

    assign wr        = chipselect && !write_n;
    assign wr_status = wr && (address == ADDR_STATUS);
    assign wr_ctrl   = wr && (address == ADDR_CONTROL);
    assign wr_per_l  = wr && (address == ADDR_PERIOD_L);
    assign wr_per_h  = wr && (address == ADDR_PERIOD_H);
    assign wr_snap   = wr && ((address == ADDR_SNAP_L) || (address == ADDR_SNAP_H));

    interval_timer_core #(
        .COUNTER_W   (COUNTER_W),
        .RESET_COUNT (RESET_VAL)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .load       (wr_per_l || wr_per_h),
        .load_value (period_d),
        .start      (wr_ctrl && writedata[CTRL_START]),
        .stop       (wr_ctrl && writedata[CTRL_STOP]),
        .cont       (ctrl_q[CTRL_CONT]),
        .always_run (ALWAYS_RUN),
        .count      (count),
        .run        (run),
        .timeout    (timeout)
    );

    // Register-file next state; a timeout beats a same-cycle STATUS clear
    always_comb begin
        period_d = period_q;
        ctrl_d   = ctrl_q;
        snap_d   = snap_q;
        to_d     = to_q;
        pulse_d  = timeout;

        if (wr_per_l) begin
            period_d[15:0] = writedata;
        end
        if (wr_per_h) begin
            period_d[COUNTER_W-1:16] = writedata[HI_W-1:0];
        end
        if (wr_ctrl) begin
            ctrl_d = writedata[1:0];
        end
        if (wr_snap) begin
            snap_d = count;
        end
        if (timeout) begin
            to_d = 1'b1;
        end else if (wr_status) begin
            to_d = 1'b0;
        end
    end

    // Read mux, registered every cycle independent of chipselect
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_STATUS: begin
                readdata_d[STAT_TO]  = to_q;
                readdata_d[STAT_RUN] = run;
            end
            ADDR_CONTROL:  readdata_d[1:0]      = ctrl_q;
            ADDR_PERIOD_L: readdata_d           = period_q[15:0];
            ADDR_PERIOD_H: readdata_d[HI_W-1:0] = period_q[COUNTER_W-1:16];
            ADDR_SNAP_L:   readdata_d           = snap_q[15:0];
            ADDR_SNAP_H:   readdata_d[HI_W-1:0] = snap_q[COUNTER_W-1:16];
            default:       readdata_d           = '0;
        endcase
    end

    // Register file, status and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q   <= RESET_VAL;
            ctrl_q     <= CTRL_RESET;
            snap_q     <= '0;
            to_q       <= 1'b0;
            pulse_q    <= 1'b0;
            readdata_q <= '0;
        end else begin
            period_q   <= period_d;
            ctrl_q     <= ctrl_d;
            snap_q     <= snap_d;
            to_q       <= to_d;
            pulse_q    <= pulse_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata      = readdata_q;
    assign irq           = to_q && ctrl_q[CTRL_ITO];
    assign timeout_pulse = pulse_q;

endmodule
